mixer_nlevel: RTL and testbench

MIXER_NLEVEL -- requirements
Module: mixer_nlevel

---
 rtl/mixer_pkg.sv | 53 +++++
 rtl/dc_tracker.sv | 44 ++++
 rtl/mixer_nlevel.sv | 184 ++++++++++++++++++
 tb/tb_mixer_nlevel.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared definitions for the mixer family: derived datapath widths, the RF
// midscale constant and the saturating narrow used on every mixer output.
package mixer_pkg;

    localparam int WIDE_W = 32;

    function automatic int d_w(input int rfBits);
        return rfBits + 2;
    endfunction

    function automatic int p_w(input int rfBits, input int loBits);
        return d_w(rfBits) + loBits;
    endfunction

    function automatic int midscale(input int rfBits);
        return 1 << (rfBits - 1);
    endfunction

    // Widths for the default 3-bit RF / 6-bit LO configuration
    localparam int D_W      = d_w(3);
    localparam int P_W      = p_w(3, 6);
    localparam int MIDSCALE = midscale(3);

    function automatic logic signed [WIDE_W-1:0] sat_hi(input int outBits);
        return WIDE_W'((1 << (outBits - 1)) - 1);
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_lo(input int outBits);
        return WIDE_W'(-(1 << (outBits - 1)));
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_narrow(
        input logic signed [WIDE_W-1:0] v,
        input int                       outBits
    );
        logic signed [WIDE_W-1:0] result;
        result = v;
        if (v > sat_hi(outBits)) begin
            result = sat_hi(outBits);
        end else if (v < sat_lo(outBits)) begin
            result = sat_lo(outBits);
        end
        return result;
    endfunction

    function automatic logic is_sat(
        input logic signed [WIDE_W-1:0] v,
        input int                       outBits
    );
        return (v > sat_hi(outBits)) || (v < sat_lo(outBits));
    endfunction

endpackage

// File: rtl/dc_tracker.sv
// Leaky-integrator DC estimator: acc converges to 2^DC_SHIFT times the mean of
// x, and dc_est is that mean. Disabling clears the estimate immediately.
module dc_tracker
    import mixer_pkg::*;
#(
    parameter int RF_BITS  = 3,
    parameter int DC_SHIFT = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic                      valid,
    input  logic signed [RF_BITS:0]   x,
    output logic signed [RF_BITS+1:0] dc_est
);

    localparam int ACC_W = RF_BITS + 2 + DC_SHIFT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] leak;

    always_comb begin
        leak  = acc_q >>> DC_SHIFT;
        acc_d = acc_q;
        if (!en) begin
            acc_d = '0;
        end else if (valid) begin
            acc_d = acc_q + ACC_W'(x) - leak;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Upper bits of acc are exactly the arithmetic shift by DC_SHIFT
    assign dc_est = en ? $signed(acc_q[ACC_W-1:DC_SHIFT]) : '0;

endmodule

// File: rtl/mixer_nlevel.sv
// N-level RF mixer: slices an offset-binary RF code, removes DC, multiplies by
// the NCO sin/cos pair and produces saturated I/Q through a 5-stage pipeline.
module mixer_nlevel
    import mixer_pkg::*;
#(
    parameter int RF_BITS  = 3,
    parameter int LO_BITS  = 6,
    parameter int OUT_BITS = 8,
    parameter int DC_SHIFT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [RF_BITS-1:0]         RF_in,
    input  logic                       RF_valid,
    input  logic signed [LO_BITS-1:0]  sin_in,
    input  logic signed [LO_BITS-1:0]  cos_in,
    input  logic [1:0]                 gain_shift,
    input  logic                       dc_en,
    input  logic                       sat_clr,
    output logic                       RF_out,
    output logic signed [OUT_BITS-1:0] I_out,
    output logic signed [OUT_BITS-1:0] Q_out,
    output logic                       IQ_valid,
    output logic                       sat_flag
);

    localparam int DW = d_w(RF_BITS);
    localparam int PW = p_w(RF_BITS, LO_BITS);
    localparam logic signed [RF_BITS:0] MID = (RF_BITS + 1)'(midscale(RF_BITS));

    // S1 / S2: capture and re-register; gain and dc_en ride with the sample
    logic [RF_BITS-1:0]        rf1_q, rf2_q;
    logic                      valid1_q, valid2_q;
    logic [1:0]                gain1_q, gain2_q;
    logic                      dcEn1_q, dcEn2_q;
    logic signed [LO_BITS-1:0] sin1_q, sin2_q, cos1_q, cos2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rf1_q    <= '0;
            valid1_q <= 1'b0;
            gain1_q  <= '0;
            dcEn1_q  <= 1'b0;
            sin1_q   <= '0;
            cos1_q   <= '0;
            rf2_q    <= '0;
            valid2_q <= 1'b0;
            gain2_q  <= '0;
            dcEn2_q  <= 1'b0;
            sin2_q   <= '0;
            cos2_q   <= '0;
        end else begin
            rf1_q    <= RF_in;
            valid1_q <= RF_valid;
            gain1_q  <= gain_shift;
            dcEn1_q  <= dc_en;
            sin1_q   <= sin_in;
            cos1_q   <= cos_in;
            rf2_q    <= rf1_q;
            valid2_q <= valid1_q;
            gain2_q  <= gain1_q;
            dcEn2_q  <= dcEn1_q;
            sin2_q   <= sin1_q;
            cos2_q   <= cos1_q;
        end
    end

    // S3: centre the code, subtract the tracked DC and slice the sign
    logic signed [RF_BITS:0]   xCentred;
    logic signed [DW-1:0]      dcEst;
    logic signed [DW-1:0]      d_d, d_q;
    logic                      rfOut_d, rfOut_q;
    logic                      valid3_q;
    logic [1:0]                gain3_q;
    logic signed [LO_BITS-1:0] sin3_q, cos3_q;

    dc_tracker #(
        .RF_BITS (RF_BITS),
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_tracker (
        .CLK   (CLK),
        .RST   (RST),
        .en    (dcEn2_q),
        .valid (valid2_q),
        .x     (xCentred),
        .dc_est(dcEst)
    );

    always_comb begin
        xCentred = $signed({1'b0, rf2_q}) - MID;
        d_d      = DW'(xCentred) - dcEst;
        rfOut_d  = rfOut_q;
        if (valid2_q) begin
            rfOut_d = ~d_d[DW-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_q      <= '0;
            rfOut_q  <= 1'b0;
            valid3_q <= 1'b0;
            gain3_q  <= '0;
            sin3_q   <= '0;
            cos3_q   <= '0;
        end else begin
            d_q      <= d_d;
            rfOut_q  <= rfOut_d;
            valid3_q <= valid2_q;
            gain3_q  <= gain2_q;
            sin3_q   <= sin2_q;
            cos3_q   <= cos2_q;
        end
    end

    // S4: full-precision products
    logic signed [PW-1:0] pI_d, pI_q, pQ_d, pQ_q;
    logic                 valid4_q;
    logic [1:0]           gain4_q;

    always_comb begin
        pI_d = PW'(d_q) * PW'(cos3_q);
        pQ_d = PW'(d_q) * PW'(sin3_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pI_q     <= '0;
            pQ_q     <= '0;
            valid4_q <= 1'b0;
            gain4_q  <= '0;
        end else begin
            pI_q     <= pI_d;
            pQ_q     <= pQ_d;
            valid4_q <= valid3_q;
            gain4_q  <= gain3_q;
        end
    end

    // S5: apply gain, clamp, and hold outputs across bubbles
    logic signed [WIDE_W-1:0]   iWide, qWide;
    logic signed [OUT_BITS-1:0] iOut_d, iOut_q, qOut_d, qOut_q;
    logic                       iqValid_q;
    logic                       satFlag_d, satFlag_q;

    always_comb begin
        iWide     = WIDE_W'(pI_q) <<< gain4_q;
        qWide     = WIDE_W'(pQ_q) <<< gain4_q;
        iOut_d    = iOut_q;
        qOut_d    = qOut_q;
        satFlag_d = satFlag_q;
        if (sat_clr) begin
            satFlag_d = 1'b0;
        end
        if (valid4_q) begin
            iOut_d = OUT_BITS'(sat_narrow(iWide, OUT_BITS));
            qOut_d = OUT_BITS'(sat_narrow(qWide, OUT_BITS));
            if (is_sat(iWide, OUT_BITS) || is_sat(qWide, OUT_BITS)) begin
                satFlag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            iOut_q    <= '0;
            qOut_q    <= '0;
            iqValid_q <= 1'b0;
            satFlag_q <= 1'b0;
        end else begin
            iOut_q    <= iOut_d;
            qOut_q    <= qOut_d;
            iqValid_q <= valid4_q;
            satFlag_q <= satFlag_d;
        end
    end

    assign RF_out   = rfOut_q;
    assign I_out    = iOut_q;
    assign Q_out    = qOut_q;
    assign IQ_valid = iqValid_q;
    assign sat_flag = satFlag_q;

endmodule

// File: tb/tb_mixer_nlevel.sv
// Directed bench for mixer_nlevel: single-sample vector table followed by
// hand-written sequences for sticky saturation, DC tracking, bubbles and reset.
module tb_mixer_nlevel;

    logic              CLK = 1'b0;
    logic              RST;
    logic [2:0]        RF_in;
    logic              RF_valid;
    logic signed [5:0] sin_in;
    logic signed [5:0] cos_in;
    logic [1:0]        gain_shift;
    logic              dc_en;
    logic              sat_clr;
    logic              RF_out;
    logic signed [7:0] I_out;
    logic signed [7:0] Q_out;
    logic              IQ_valid;
    logic              sat_flag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int rf;
        int sinv;
        int cosv;
        int gain;
        int expI;
        int expQ;
        int expRf;
        int expSat;
    } vec_t;

    vec_t vecs[7];

    mixer_nlevel #(
        .RF_BITS (3),
        .LO_BITS (6),
        .OUT_BITS(8),
        .DC_SHIFT(4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RF_in     (RF_in),
        .RF_valid  (RF_valid),
        .sin_in    (sin_in),
        .cos_in    (cos_in),
        .gain_shift(gain_shift),
        .dc_en     (dc_en),
        .sat_clr   (sat_clr),
        .RF_out    (RF_out),
        .I_out     (I_out),
        .Q_out     (Q_out),
        .IQ_valid  (IQ_valid),
        .sat_flag  (sat_flag)
    );

    always #5 CLK = ~CLK;

    // One rising edge, then settle before anything is sampled or driven
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int rf, input int sinv, input int cosv,
                                 input int gain, input int valid, input int dcEn);
        RF_in      = 3'(rf);
        sin_in     = 6'(sinv);
        cos_in     = 6'(cosv);
        gain_shift = 2'(gain);
        RF_valid   = 1'(valid);
        dc_en      = 1'(dcEn);
    endtask

    // Single pulse: RF_out after edge 3, IQ_valid only after edge 5
    task automatic runVector(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        applyStimulus(v.rf, v.sinv, v.cosv, v.gain, 1, 0);
        step();
        RF_valid = 1'b0;
        step();
        step();
        checkOutput({tag, "_rf_out"}, int'(RF_out), v.expRf);
        step();
        checkOutput({tag, "_iqv_early"}, int'(IQ_valid), 0);
        step();
        checkOutput({tag, "_iqv"}, int'(IQ_valid), 1);
        checkOutput({tag, "_I"}, int'(I_out), v.expI);
        checkOutput({tag, "_Q"}, int'(Q_out), v.expQ);
        checkOutput({tag, "_sat"}, int'(sat_flag), v.expSat);
        step();
        checkOutput({tag, "_iqv_late"}, int'(IQ_valid), 0);
        checkOutput({tag, "_I_hold"}, int'(I_out), v.expI);
    endtask

    int pRf[4]   = '{7, 0, 5, 1};
    int pSin[4]  = '{-32, 0, 10, -7};
    int pCos[4]  = '{31, 0, -20, 9};
    int pGain[4] = '{0, 3, 2, 1};
    int pV[4]    = '{1, 0, 1, 1};
    int eI[4]    = '{93, 93, -80, -54};
    int eQ[4]    = '{-96, -96, 40, 42};

    initial begin
        bit sawValid;

        //              rf  sin  cos gain   I     Q   rf sat
        vecs[0] = '{7, -32,  31, 0,   93,  -96, 1, 0};
        vecs[1] = '{7, -32,  31, 1,  127, -128, 1, 1};
        vecs[2] = '{0,   0, -32, 0,  127,    0, 0, 1};
        vecs[3] = '{5,  10, -20, 2,  -80,   40, 1, 0};
        vecs[4] = '{3,  31,  31, 3, -128, -128, 0, 1};
        vecs[5] = '{4,  -5,  17, 3,    0,    0, 1, 0};
        vecs[6] = '{1,  -7,   9, 1,  -54,   42, 0, 0};

        RST     = 1'b1;
        sat_clr = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        checkOutput("rst_iqv", int'(IQ_valid), 0);
        checkOutput("rst_I", int'(I_out), 0);
        checkOutput("rst_Q", int'(Q_out), 0);
        checkOutput("rst_rf_out", int'(RF_out), 0);
        checkOutput("rst_sat", int'(sat_flag), 0);
        RST = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            runVector(vecs[i], i);
        end

        // Clamp lands on the same edge as sat_clr: set must win, then stick
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        applyStimulus(7, -32, 31, 1, 1, 0);
        step();
        RF_valid = 1'b0;
        step();
        step();
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        checkOutput("sat_set_wins", int'(sat_flag), 1);
        step();
        step();
        checkOutput("sat_sticky", int'(sat_flag), 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        checkOutput("sat_clr", int'(sat_flag), 0);

        // DC tracker settles to dc_est=2 on a constant code of 6
        applyStimulus(6, 0, 31, 0, 1, 1);
        repeat (200) step();
        checkOutput("dc_settled_I", int'(I_out), 0);
        checkOutput("dc_settled_Q", int'(Q_out), 0);
        checkOutput("dc_settled_rf", int'(RF_out), 1);
        checkOutput("dc_settled_iqv", int'(IQ_valid), 1);
        dc_en = 1'b0;
        repeat (4) step();
        checkOutput("dc_inflight_I", int'(I_out), 0);
        step();
        checkOutput("dc_off_I", int'(I_out), 62);
        RF_valid = 1'b0;
        repeat (6) step();

        // Valid pattern 1,0,1,1 with per-sample gain
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pRf[i], pSin[i], pCos[i], pGain[i], pV[i], 0);
            step();
        end
        RF_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("pat%0d_iqv", i), int'(IQ_valid), pV[i]);
            checkOutput($sformatf("pat%0d_I", i), int'(I_out), eI[i]);
            checkOutput($sformatf("pat%0d_Q", i), int'(Q_out), eQ[i]);
        end
        repeat (3) step();

        // Mid-stream reset with the DC tracker loaded and sat_flag set
        applyStimulus(6, -32, 31, 1, 1, 1);
        repeat (40) step();
        RST      = 1'b1;
        RF_valid = 1'b0;
        step();
        RST = 1'b0;
        checkOutput("mrst_iqv", int'(IQ_valid), 0);
        checkOutput("mrst_I", int'(I_out), 0);
        checkOutput("mrst_Q", int'(Q_out), 0);
        checkOutput("mrst_rf_out", int'(RF_out), 0);
        checkOutput("mrst_sat", int'(sat_flag), 0);
        sawValid = 1'b0;
        repeat (6) begin
            step();
            if (IQ_valid) sawValid = 1'b1;
        end
        checkOutput("mrst_no_stale_iqv", int'(sawValid), 0);
        applyStimulus(6, -32, 31, 0, 1, 1);
        step();
        RF_valid = 1'b0;
        repeat (3) step();
        checkOutput("mrst_iqv_early", int'(IQ_valid), 0);
        step();
        checkOutput("mrst_iqv_first", int'(IQ_valid), 1);
        checkOutput("mrst_acc_restart_I", int'(I_out), 62);
        checkOutput("mrst_acc_restart_Q", int'(Q_out), -64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
